// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-entry holding register so back-to-back
// words stream out with no idle cycles between them.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      word_count
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] PenultIdx = IdxW'(WIDTH - 2);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [IdxW-1:0]  idx_q;
  logic             out_bit_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [15:0]      word_count_q;

  logic             xfer;
  logic             at_last;
  logic             load_en;
  logic             to_hold;
  logic [WIDTH-1:0] load_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift so the next bit to present sits where first_bit() looks.
  function automatic logic [WIDTH-1:0] advance_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_comb begin
    xfer      = in_valid & ~hold_full_q;
    at_last   = (state_q == StShift) & (idx_q == LastIdx);
    // hold_full_q and xfer are mutually exclusive, so hold takes priority safely.
    load_en   = ((state_q == StIdle) & xfer) | (at_last & (hold_full_q | xfer));
    load_word = hold_full_q ? hold_q : in_data;
    to_hold   = xfer & (state_q == StShift) & ~at_last;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      idx_q        <= '0;
      out_bit_q    <= IDLE_BIT;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      if (xfer) begin
        word_count_q <= word_count_q + 16'd1;
      end

      if (to_hold) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end else if (load_en && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (load_en) begin
            state_q     <= StShift;
            shift_q     <= advance_word(load_word);
            out_bit_q   <= first_bit(load_word);
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            idx_q       <= '0;
          end
        end
        StShift: begin
          if (load_en) begin
            shift_q     <= advance_word(load_word);
            out_bit_q   <= first_bit(load_word);
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            idx_q       <= '0;
          end else if (at_last) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            out_bit_q   <= IDLE_BIT;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            idx_q       <= '0;
          end else begin
            shift_q    <= advance_word(shift_q);
            out_bit_q  <= first_bit(shift_q);
            out_last_q <= (idx_q == PenultIdx);
            idx_q      <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = ~hold_full_q;
  assign out_bit    = out_bit_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = out_valid_q | hold_full_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance.
module tb_bit_serializer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  m_data = '0, l_data = '0;
  logic        m_valid = 1'b0, l_valid = 1'b0;
  logic        m_ready, m_bit, m_ovalid, m_last, m_busy;
  logic        l_ready, l_bit, l_ovalid, l_last, l_busy;
  logic [15:0] m_count, l_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clock(clock), .reset_n(reset_n), .in_data(m_data), .in_valid(m_valid),
    .in_ready(m_ready), .out_bit(m_bit), .out_valid(m_ovalid), .out_last(m_last),
    .busy(m_busy), .word_count(m_count)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clock(clock), .reset_n(reset_n), .in_data(l_data), .in_valid(l_valid),
    .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_ovalid), .out_last(l_last),
    .busy(l_busy), .word_count(l_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    m_valid = 1'b0;
    l_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", m_ready); end
    checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", m_ovalid); end
    checks++; if (m_bit !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b want=0", m_bit); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", m_last); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", m_busy); end
    checks++; if (m_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", m_count); end
    checks++; if (l_ovalid !== 1'b0) begin failures++; $display("FAIL reset_lsb_valid got=%b want=0", l_ovalid); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'b1011_0011;
    do_reset();
    m_data = w;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (m_bit !== w[7-k]) begin failures++; $display("FAIL single_bit%0d got=%b want=%b", k, m_bit, w[7-k]); end
      checks++; if (m_ovalid !== 1'b1) begin failures++; $display("FAIL single_valid%0d got=%b want=1", k, m_ovalid); end
      checks++; if (m_last !== (k == 7)) begin failures++; $display("FAIL single_last%0d got=%b want=%b", k, m_last, (k == 7)); end
      tick();
    end
    checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%b want=0", m_ovalid); end
    checks++; if (m_bit !== 1'b0) begin failures++; $display("FAIL single_after_bit got=%b want=0", m_bit); end
    checks++; if (m_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d want=1", m_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [7:0] cur;
    int widx;
    logic pend;
    logic exp_rdy;
    w[0] = 8'hF0; w[1] = 8'h0F; w[2] = 8'hAA;
    do_reset();
    widx = 0;
    m_data = w[0];
    m_valid = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      pend = m_valid & m_ready;
      tick();
      if (pend) begin
        widx++;
        if (widx < 3) m_data = w[widx];
        else m_valid = 1'b0;
      end
      exp_rdy = !((cyc >= 2 && cyc <= 8) || (cyc >= 10 && cyc <= 16));
      checks++; if (m_ready !== exp_rdy) begin failures++; $display("FAIL b2b_ready c%0d got=%b want=%b", cyc, m_ready, exp_rdy); end
      if (cyc <= 24) begin
        cur = w[(cyc-1)/8];
        checks++; if (m_bit !== cur[7-((cyc-1)%8)]) begin failures++; $display("FAIL b2b_bit c%0d got=%b want=%b", cyc, m_bit, cur[7-((cyc-1)%8)]); end
        checks++; if (m_ovalid !== 1'b1) begin failures++; $display("FAIL b2b_valid c%0d got=%b want=1", cyc, m_ovalid); end
        checks++; if (m_last !== (cyc % 8 == 0)) begin failures++; $display("FAIL b2b_last c%0d got=%b want=%b", cyc, m_last, (cyc % 8 == 0)); end
        checks++; if (m_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy c%0d got=%b want=1", cyc, m_busy); end
      end else begin
        checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b want=0", m_ovalid); end
        checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b want=0", m_busy); end
        checks++; if (m_count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%0d want=3", m_count); end
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b1100_0000;  // emission order, first bit at [7]
    do_reset();
    l_data = 8'b0000_0011;
    l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (l_bit !== exp_bits[7-k]) begin failures++; $display("FAIL lsb_bit%0d got=%b want=%b", k, l_bit, exp_bits[7-k]); end
      checks++; if (l_last !== (k == 7)) begin failures++; $display("FAIL lsb_last%0d got=%b want=%b", k, l_last, (k == 7)); end
      tick();
    end
    checks++; if (l_ovalid !== 1'b0) begin failures++; $display("FAIL lsb_after_valid got=%b want=0", l_ovalid); end
    checks++; if (l_count !== 16'd1) begin failures++; $display("FAIL lsb_count got=%0d want=1", l_count); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    w = 8'h81;
    do_reset();
    m_data = 8'hFF;
    m_valid = 1'b1;
    tick();
    m_data = 8'h5A;
    tick();
    m_valid = 1'b0;
    tick();
    tick();
    checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL midrst_pre_ready got=%b want=0", m_ready); end
    checks++; if (m_bit !== 1'b1) begin failures++; $display("FAIL midrst_pre_bit got=%b want=1", m_bit); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", m_ovalid); end
    checks++; if (m_bit !== 1'b0) begin failures++; $display("FAIL midrst_bit got=%b want=0", m_bit); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", m_busy); end
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b want=1", m_ready); end
    checks++; if (m_count !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d want=0", m_count); end
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL midrst_residual%0d got=%b want=0", k, m_ovalid); end
    end
    m_data = w;
    m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (m_bit !== w[7-k]) begin failures++; $display("FAIL midrst_bit%0d got=%b want=%b", k, m_bit, w[7-k]); end
      tick();
    end
    checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL midrst_end_valid got=%b want=0", m_ovalid); end
    checks++; if (m_count !== 16'd1) begin failures++; $display("FAIL midrst_end_count got=%0d want=1", m_count); end
  endtask

  task automatic test_gaps();
    logic [7:0] w [2];
    w[0] = 8'h3C; w[1] = 8'hC5;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      m_data = w[n];
      m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        checks++; if (m_bit !== w[n][7-k]) begin failures++; $display("FAIL gap_w%0d_bit%0d got=%b want=%b", n, k, m_bit, w[n][7-k]); end
        checks++; if (m_ovalid !== 1'b1) begin failures++; $display("FAIL gap_w%0d_valid%0d got=%b want=1", n, k, m_ovalid); end
        tick();
      end
      for (int g = 0; g < 3; g++) begin
        checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL gap_idle_valid w%0d g%0d got=%b want=0", n, g, m_ovalid); end
        checks++; if (m_bit !== 1'b0) begin failures++; $display("FAIL gap_idle_bit w%0d g%0d got=%b want=0", n, g, m_bit); end
        if (g < 2) tick();
      end
    end
    checks++; if (m_count !== 16'd2) begin failures++; $display("FAIL gap_count got=%0d want=2", m_count); end
  endtask

  task automatic test_data_change_stalled();
    logic [7:0] w [2];
    logic [7:0] cur;
    w[0] = 8'h96; w[1] = 8'h3C;
    do_reset();
    for (int cyc = 1; cyc <= 17; cyc++) begin
      if (cyc <= 2) begin
        m_data = w[cyc-1];
        m_valid = 1'b1;
      end else if (cyc <= 8) begin
        m_data = 8'hFF ^ 8'(cyc);
        m_valid = 1'b1;
      end else begin
        m_data = 8'hFF;
        m_valid = 1'b0;
      end
      tick();
      if (cyc >= 2 && cyc <= 8) begin
        checks++; if (m_ready !== 1'b0) begin failures++; $display("FAIL stall_ready c%0d got=%b want=0", cyc, m_ready); end
      end
      if (cyc <= 16) begin
        cur = w[(cyc-1)/8];
        checks++; if (m_bit !== cur[7-((cyc-1)%8)]) begin failures++; $display("FAIL stall_bit c%0d got=%b want=%b", cyc, m_bit, cur[7-((cyc-1)%8)]); end
      end else begin
        checks++; if (m_ovalid !== 1'b0) begin failures++; $display("FAIL stall_end_valid got=%b want=0", m_ovalid); end
        checks++; if (m_count !== 16'd2) begin failures++; $display("FAIL stall_count got=%0d want=2", m_count); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_gaps();
    test_data_change_stalled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
